// File: rtl/rr_arbiter4_pkg.sv
// Shared constants, output-stage state type and small index helpers for the
// four-requester round-robin arbiter.
package rr_arbiter4_pkg;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam logic [ID_W-1:0] LAST_RESET = 2'd3;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ostate_t;

  // Converts a one-hot grant into its index; zero maps to index 0.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [ID_W-1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Bits strictly above the last granted index stay eligible for the masked pick.
  function automatic logic [NREQ-1:0] above_mask(input logic [ID_W-1:0] last);
    logic [NREQ-1:0] mask;
    case (last)
      2'd0:    mask = 4'b1110;
      2'd1:    mask = 4'b1100;
      2'd2:    mask = 4'b1000;
      2'd3:    mask = 4'b0000;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/rr_arbiter4_pick_lowest4.sv
// Stateless lowest-set-bit isolator: one-hot grant of the lowest request
// plus a flag telling whether any request was present.
module pick_lowest4
  import rr_arbiter4_pkg::*;
(
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    grant = req & (~req + 4'd1);
    any   = |req;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter feeding a single registered output slot that
// can drain and refill in the same cycle.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  asyncresetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  o_valid,
  output logic [WIDTH-1:0]      o_data,
  output logic [ID_W-1:0]       o_id,
  input  logic                  o_ready
);

  ostate_t           state_r;
  ostate_t           state_nxt_s;
  logic [ID_W-1:0]   last_r;
  logic [WIDTH-1:0]  o_data_r;
  logic [ID_W-1:0]   o_id_r;

  logic [NREQ-1:0]   masked_req_s;
  logic [NREQ-1:0]   masked_grant_s;
  logic              masked_any_s;
  logic [NREQ-1:0]   full_grant_s;
  logic              full_any_s;
  logic [NREQ-1:0]   win_oh_s;
  logic [ID_W-1:0]   win_idx_s;
  logic [WIDTH-1:0]  win_data_s;
  logic              accept_s;

  assign masked_req_s = req_valid & above_mask(last_r);

  pick_lowest4 u_pick_masked (
    .req   (masked_req_s),
    .grant (masked_grant_s),
    .any   (masked_any_s)
  );

  pick_lowest4 u_pick_full (
    .req   (req_valid),
    .grant (full_grant_s),
    .any   (full_any_s)
  );

  // Winner selection, acceptance and payload mux.
  always_comb begin
    win_oh_s   = full_grant_s;
    win_data_s = {WIDTH{1'b0}};
    if (masked_any_s) begin
      win_oh_s = masked_grant_s;
    end else begin
      win_oh_s = full_grant_s;
    end
    win_idx_s = onehot_to_idx(win_oh_s);
    accept_s  = full_any_s & ((state_r == EMPTY) | o_ready);
    case (win_idx_s)
      2'd0:    win_data_s = req_data[0*WIDTH +: WIDTH];
      2'd1:    win_data_s = req_data[1*WIDTH +: WIDTH];
      2'd2:    win_data_s = req_data[2*WIDTH +: WIDTH];
      2'd3:    win_data_s = req_data[3*WIDTH +: WIDTH];
      default: win_data_s = {WIDTH{1'b0}};
    endcase
  end

  // Ready is forced low while reset is held, even though winner logic is live.
  always_comb begin
    if (accept_s && asyncresetn) begin
      req_ready = win_oh_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Output-stage next state.
  always_comb begin
    state_nxt_s = state_r;
    if (accept_s) begin
      state_nxt_s = FULL;
    end else if ((state_r == FULL) && o_ready) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge asyncresetn) begin
    if (!asyncresetn) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output payload, id and round-robin pointer capture on acceptance.
  always_ff @(posedge clk or negedge asyncresetn) begin
    if (!asyncresetn) begin
      o_data_r <= {WIDTH{1'b0}};
      o_id_r   <= 2'd0;
      last_r   <= LAST_RESET;
    end else if (accept_s) begin
      o_data_r <= win_data_s;
      o_id_r   <= win_idx_s;
      last_r   <= win_idx_s;
    end else begin
      o_data_r <= o_data_r;
      o_id_r   <= o_id_r;
      last_r   <= last_r;
    end
  end

  assign o_valid = (state_r == FULL);
  assign o_data  = o_data_r;
  assign o_id    = o_id_r;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter WIDTH, default 8, payload bit width per requester.
REQ-002 CLK  input  1  sole clock; all state changes on rising edge.
REQ-003 ASYNCRESETN  input  1  reset, asynchronous, active-low.
REQ-004 REQ_VALID  input  4  per-requester valid; bit i = requester i.
REQ-005 REQ_DATA  input  4*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-006 REQ_READY  output  4  one-hot or zero; bit i high = requester i's beat accepted this cycle.
REQ-007 O_VALID  output  1  output register holds a beat.
REQ-008 O_DATA  output  WIDTH  granted payload.
REQ-009 O_ID  output  2  index of the requester that supplied O_DATA.
REQ-010 O_READY  input  1  downstream accepts the O_* beat this cycle.

Function
REQ-011 Transfer on requester i occurs in a cycle with REQ_VALID[i] & REQ_READY[i]; output transfer occurs in a cycle with O_VALID & O_READY.
REQ-012 Requesters hold REQ_VALID and REQ_DATA stable until accepted; the block does not depend on their withdrawal.
REQ-013 Internal 2-bit pointer LAST holds the index of the most recently accepted requester.
REQ-014 Winner: lowest set index among REQ_VALID bits with index > LAST; if none, lowest set index overall; no winner if REQ_VALID = 0.
REQ-015 Output stage states: EMPTY (O_VALID=0) and FULL (O_VALID=1).
REQ-016 ACCEPT = winner exists & (state EMPTY | O_READY).
REQ-017 REQ_READY[winner] = ACCEPT; all other REQ_READY bits 0; combinational from REQ_VALID, LAST, state, O_READY.
REQ-018 On ACCEPT: O_DATA <= winner payload, O_ID <= winner, LAST <= winner, state FULL; latency 1 cycle from acceptance to O_VALID.
REQ-019 FULL with O_READY=1 and no winner: state EMPTY next cycle.
REQ-020 FULL with O_READY=0: O_VALID, O_DATA, O_ID held unchanged; REQ_READY = 0.
REQ-021 FULL with O_READY=1 and a winner: drain and refill same cycle; O_VALID stays 1; sustained throughput 1 beat/cycle.
REQ-022 EMPTY with no winner: all outputs hold; LAST unchanged.
REQ-023 Single persistent requester is granted every cycle it is eligible; pointer wrap 3 -> 0 handled by the "none above LAST" rule.
REQ-024 Fairness: with all four valid continuously and O_READY=1, grant order is cyclic; no requester waits more than 3 accepted beats.
REQ-025 O_READY while EMPTY is ignored.

Reset
REQ-026 ASYNCRESETN low forces immediately, independent of CLK: state EMPTY, O_VALID=0, O_DATA=0, O_ID=0, LAST=3.
REQ-027 While reset is asserted, REQ_READY = 0.
REQ-028 Reset mid-operation discards any held beat without an output transfer; first grant after release favours requester 0.
REQ-029 Deassertion takes effect at the next rising CLK edge.

Structure
REQ-030 Shared package: NREQ=4, ID_W=2, LAST_RESET=3, output-state enumeration {EMPTY, FULL}.
REQ-031 One sub-module, pick_lowest4: combinational 4-bit lowest-set-bit isolator returning one-hot grant and any-valid flag; instantiated twice, once for masked and once for unmasked requests.
REQ-032 All registers are in rr_arbiter4; pick_lowest4 holds no state.

Verification
REQ-033 Reset, then REQ_VALID=4'b1111, O_READY=1 for 8 cycles -> O_ID sequence 0,1,2,3,0,1,2,3; REQ_READY one-hot each cycle.
REQ-034 REQ_VALID=4'b0100 with data 8'hA5, O_READY=0 -> one accept, O_VALID=1, O_DATA=8'hA5, O_ID=2 held; REQ_READY=0 until O_READY=1.
REQ-035 LAST=3, REQ_VALID=4'b1010 -> requester 1 granted; then LAST=1, REQ_VALID=4'b1010 -> requester 3 granted.
REQ-036 FULL, O_READY=1, REQ_VALID=0 -> O_VALID falls next cycle; output O_READY then toggled while EMPTY -> no change.
REQ-037 ASYNCRESETN pulsed low between clock edges while FULL -> O_VALID drops before next edge; after release, REQ_VALID=4'b1001 -> requester 0 granted first.
REQ-038 Random REQ_VALID/O_READY for 10k cycles against a scoreboard -> no lost, duplicated or reordered beats per requester; max wait 3 beats.
